// File: rtl/line_stream_pkg.sv
// Shared encodings for the line streamer: request modes, FSM states and default widths.
// Imported by every file of the block so encodings never drift apart.
package line_stream_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_LINE_W = 6;
    localparam int DEF_LEN_W  = 6;
    localparam int DEF_CHAR_W = 8;

    typedef enum logic [1:0] {
        MODE_LHS  = 2'b00,
        MODE_RHS  = 2'b01,
        MODE_ILV  = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DLOOK  = 3'd1,
        ST_DLATCH = 3'd2,
        ST_MREAD  = 3'd3,
        ST_EMIT   = 3'd4,
        ST_FIN    = 3'd5
    } state_e;

endpackage

// File: rtl/line_desc_unpack.sv
// Splits a line descriptor word {len, start} into its fields.
// Purely combinational, zero latency, no flow control.
module line_desc_unpack
    import line_stream_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic [LEN_W+ADDR_W-1:0] desc_data,
    output logic [ADDR_W-1:0]       desc_start,
    output logic [LEN_W-1:0]        desc_len
);

    assign desc_start = desc_data[ADDR_W-1:0];
    assign desc_len   = desc_data[LEN_W+ADDR_W-1:ADDR_W];

endmodule

// File: rtl/line_streamer.sv
// Streams one text line per request out of a dual-half character memory; first beat 4 cycles after accept.
// Holds out_char under out_ready backpressure; never issues a memory read while a beat is pending.
module line_streamer
    import line_stream_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int LINE_W    = DEF_LINE_W,
    parameter int LEN_W     = DEF_LEN_W,
    parameter int CHAR_W    = DEF_CHAR_W,
    parameter int NUM_LINES = 2**LINE_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [LINE_W-1:0]       req_line,
    input  logic [1:0]              req_mode,
    output logic [LINE_W-1:0]       desc_addr,
    input  logic [LEN_W+ADDR_W-1:0] desc_data,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_rd,
    input  logic [2*CHAR_W-1:0]     mem_dout,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CHAR_W-1:0]       out_char,
    output logic                    out_last,
    output logic                    done,
    output logic                    err,
    output logic                    busy
);

    state_e                state_q, state_d;
    logic [LINE_W-1:0]     line_q, line_d;
    mode_e                 mode_q, mode_d;
    logic                  err_q, err_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [LEN_W-1:0]      rem_q, rem_d;
    logic                  beat_q, beat_d;
    logic [2*CHAR_W-1:0]   word_q, word_d;
    logic                  word_vld_q, word_vld_d;

    logic [ADDR_W-1:0]     desc_start;
    logic [LEN_W-1:0]      desc_len;
    logic                  bad_req;
    logic [2*CHAR_W-1:0]   cur_word;
    logic                  lhs_sel;
    logic                  word_done;
    logic [CHAR_W-1:0]     emit_char;

    line_desc_unpack #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_desc_unpack (
        .desc_data  (desc_data),
        .desc_start (desc_start),
        .desc_len   (desc_len)
    );

    assign bad_req = (32'(req_line) >= 32'(NUM_LINES)) || (req_mode == MODE_RSVD);

    // Memory data is only valid in the first EMIT cycle; afterwards the latched copy is used.
    assign cur_word  = word_vld_q ? word_q : mem_dout;
    assign lhs_sel   = (mode_q == MODE_LHS) || ((mode_q == MODE_ILV) && !beat_q);
    assign emit_char = lhs_sel ? cur_word[2*CHAR_W-1:CHAR_W] : cur_word[CHAR_W-1:0];
    assign word_done = (mode_q != MODE_ILV) || beat_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            line_q     <= '0;
            mode_q     <= MODE_LHS;
            err_q      <= 1'b0;
            mem_addr_q <= '0;
            rem_q      <= '0;
            beat_q     <= 1'b0;
            word_q     <= '0;
            word_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            mode_q     <= mode_d;
            err_q      <= err_d;
            mem_addr_q <= mem_addr_d;
            rem_q      <= rem_d;
            beat_q     <= beat_d;
            word_q     <= word_d;
            word_vld_q <= word_vld_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        mode_d     = mode_q;
        err_d      = err_q;
        mem_addr_d = mem_addr_q;
        rem_d      = rem_q;
        beat_d     = beat_q;
        word_d     = word_q;
        word_vld_d = word_vld_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    line_d  = req_line;
                    mode_d  = mode_e'(req_mode);
                    err_d   = bad_req;
                    state_d = bad_req ? ST_FIN : ST_DLOOK;
                end
            end
            ST_DLOOK: begin
                state_d = ST_DLATCH;
            end
            ST_DLATCH: begin
                beat_d = 1'b0;
                if (desc_len == '0) begin
                    state_d = ST_FIN;
                end else begin
                    mem_addr_d = desc_start;
                    rem_d      = desc_len;
                    state_d    = ST_MREAD;
                end
            end
            ST_MREAD: begin
                word_vld_d = 1'b0;
                state_d    = ST_EMIT;
            end
            ST_EMIT: begin
                if (!word_vld_q) begin
                    word_d     = mem_dout;
                    word_vld_d = 1'b1;
                end
                if (out_ready) begin
                    if (!word_done) begin
                        beat_d = 1'b1;
                    end else begin
                        beat_d = 1'b0;
                        rem_d  = rem_q - 1'b1;
                        if (rem_q != LEN_W'(1)) begin
                            mem_addr_d = mem_addr_q + 1'b1;
                            state_d    = ST_MREAD;
                        end else begin
                            state_d = ST_FIN;
                        end
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are forced low while rst_n is asserted, not just from the next edge.
    always_comb begin
        req_ready = 1'b0;
        desc_addr = '0;
        mem_addr  = '0;
        mem_rd    = 1'b0;
        out_valid = 1'b0;
        out_char  = '0;
        out_last  = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        busy      = 1'b0;
        if (rst_n) begin
            mem_addr = mem_addr_q;
            busy     = (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE:  req_ready = 1'b1;
                ST_DLOOK: desc_addr = line_q;
                ST_MREAD: mem_rd    = 1'b1;
                ST_EMIT: begin
                    out_valid = 1'b1;
                    out_char  = emit_char;
                    out_last  = word_done && (rem_q == LEN_W'(1));
                end
                ST_FIN: begin
                    done = 1'b1;
                    err  = err_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_line_streamer.sv
// Directed plus randomized bench for line_streamer against a queue-based model of the line contents.
module tb_line_streamer;
    localparam int ADDR_W    = 8;
    localparam int LINE_W    = 6;
    localparam int LEN_W     = 6;
    localparam int CHAR_W    = 8;
    localparam int NUM_LINES = 40;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    req_valid, req_ready;
    logic [LINE_W-1:0]       req_line;
    logic [1:0]              req_mode;
    logic [LINE_W-1:0]       desc_addr;
    logic [LEN_W+ADDR_W-1:0] desc_data;
    logic [ADDR_W-1:0]       mem_addr;
    logic                    mem_rd;
    logic [2*CHAR_W-1:0]     mem_dout;
    logic                    out_valid, out_ready;
    logic [CHAR_W-1:0]       out_char;
    logic                    out_last, done, err, busy;

    logic [2*CHAR_W-1:0]     mem [256];
    logic [LEN_W+ADDR_W-1:0] desc_tab [64];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    line_streamer #(
        .ADDR_W(ADDR_W), .LINE_W(LINE_W), .LEN_W(LEN_W),
        .CHAR_W(CHAR_W), .NUM_LINES(NUM_LINES)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_line(req_line), .req_mode(req_mode),
        .desc_addr(desc_addr), .desc_data(desc_data),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_dout(mem_dout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_char(out_char), .out_last(out_last),
        .done(done), .err(err), .busy(busy)
    );

    // Synchronous table and memory; memory data is garbage except the cycle after a read.
    always @(posedge clk) begin
        desc_data <= desc_tab[desc_addr];
        mem_dout  <= mem_rd ? mem[mem_addr] : 16'($urandom);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctl"}, 32'({req_ready, out_valid, out_last, done, err, mem_rd, busy}), 32'(0));
        chk({tag, "_addr"}, 32'({mem_addr, desc_addr}), 32'(0));
        chk({tag, "_char"}, 32'(out_char), 32'(0));
    endtask

    // stall: 0 always ready, 1 random ready, 2 hold ready low for 5 cycles on the first beat
    task automatic run_req(input int line, input int mode, input int stall);
        logic [CHAR_W-1:0] exp_chars[$];
        logic [ADDR_W-1:0] exp_addrs[$];
        logic [CHAR_W-1:0] prev_char;
        int len, start, k, first_k, last_fire_k, beats, total_beats, stall_cnt, n_rd, exp_done_k;
        bit bad, seen_done, prev_hold;

        bad   = (line >= NUM_LINES) || (mode == 3);
        len   = bad ? 0 : int'(desc_tab[line][LEN_W+ADDR_W-1:ADDR_W]);
        start = int'(desc_tab[line][ADDR_W-1:0]);
        for (int i = 0; i < len; i++) begin
            int a;
            a = (start + i) % (1 << ADDR_W);
            exp_addrs.push_back(ADDR_W'(a));
            if (mode == 0 || mode == 2) exp_chars.push_back(mem[a][2*CHAR_W-1:CHAR_W]);
            if (mode == 1 || mode == 2) exp_chars.push_back(mem[a][CHAR_W-1:0]);
        end
        total_beats = exp_chars.size();

        chk("idle_ready", 32'(req_ready), 32'(1));
        chk("idle_busy", 32'(busy), 32'(0));
        req_valid = 1'b1;
        req_line  = LINE_W'(line);
        req_mode  = 2'(mode);
        @(negedge clk);
        req_valid = 1'b0;
        req_line  = LINE_W'($urandom);
        req_mode  = 2'($urandom);

        k = 1; first_k = -1; last_fire_k = -1; beats = 0;
        stall_cnt = 0; n_rd = 0; seen_done = 0; prev_hold = 0; prev_char = '0;
        while (!seen_done && k < 500) begin
            if (stall == 0)      out_ready = 1'b1;
            else if (stall == 1) out_ready = 1'($urandom_range(0, 1));
            else                 out_ready = !(out_valid && beats == 0 && stall_cnt < 5);
            if (out_valid && beats == 0 && !out_ready) stall_cnt++;

            if (prev_hold) begin
                chk("hold_valid", 32'(out_valid), 32'(1));
                chk("hold_char", 32'(out_char), 32'(prev_char));
            end
            if (!done) chk("err_low", 32'(err), 32'(0));
            if (bad) chk("no_desc", 32'(desc_addr), 32'(0));
            if (mem_rd) begin
                chk("rd_no_valid", 32'(out_valid), 32'(0));
                if (n_rd < len) chk("mem_addr", 32'(mem_addr), 32'(exp_addrs[n_rd]));
                else chk("extra_rd", n_rd + 1, len);
                n_rd++;
            end
            if (out_valid) begin
                if (first_k < 0) begin
                    first_k = k;
                    chk("first_lat", k, 4);
                end
                if (exp_chars.size() == 0) begin
                    chk("extra_beat", beats + 1, total_beats);
                end else begin
                    chk("char", 32'(out_char), 32'(exp_chars[0]));
                    chk("last", 32'(out_last), 32'(exp_chars.size() == 1));
                    if (out_ready) begin
                        void'(exp_chars.pop_front());
                        beats++;
                        last_fire_k = k;
                    end
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_char = out_char;
            if (done) begin
                seen_done = 1;
                chk("err", 32'(err), 32'(bad));
                if (bad)           exp_done_k = 1;
                else if (len == 0) exp_done_k = 3;
                else               exp_done_k = last_fire_k + 1;
                chk("done_lat", k, exp_done_k);
            end
            @(negedge clk);
            k++;
        end
        chk("done_seen", 32'(seen_done), 32'(1));
        chk("beats", beats, total_beats);
        chk("rd_count", n_rd, len);
        chk("done_pulse", 32'(done), 32'(0));
        chk("back_idle", 32'(req_ready), 32'(1));
        out_ready = 1'b0;
    endtask

    initial begin
        int guard;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 64; i++)
            desc_tab[i] = {LEN_W'($urandom_range(0, 5)), ADDR_W'($urandom)};
        desc_tab[0] = {6'd3, 8'd0};
        desc_tab[1] = {6'd2, 8'd20};
        desc_tab[2] = {6'd0, 8'd7};
        desc_tab[3] = {6'd2, 8'd255};
        desc_tab[5] = {6'd4, 8'd10};
        desc_tab[6] = {6'd5, 8'd253};

        req_valid = 1'b0; req_line = '0; req_mode = '0; out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", 32'(req_ready), 32'(1));

        run_req(0, 2, 0);   // six interleaved beats
        run_req(1, 0, 2);   // stall on first beat
        run_req(2, 1, 0);   // zero-length line
        run_req(40, 0, 0);  // line out of range
        run_req(4, 3, 0);   // reserved mode
        run_req(3, 1, 1);   // address wrap 255 -> 0
        run_req(6, 2, 1);

        // Reset during the second beat of an interleaved line
        out_ready = 1'b1;
        req_valid = 1'b1; req_line = 6'd5; req_mode = 2'b10;
        @(negedge clk);
        req_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("rst_wait_beat", 32'(out_valid), 32'(1));
        @(negedge clk);
        chk("rst_second_beat", 32'(out_valid), 32'(1));
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        @(negedge clk);
        chk_reset_outputs("mid_reset_held");
        rst_n = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("rel_ready", 32'(req_ready), 32'(1));
        chk("rel_no_done", 32'(done), 32'(0));
        run_req(5, 2, 0);

        for (int i = 0; i < 30; i++)
            run_req($urandom_range(0, 63), $urandom_range(0, 3), $urandom_range(0, 2));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/line_streamer.md
LINE_STREAMER -- requirements
Module: line_streamer

Interface
REQ-001 Parameter ADDR_W, default 8, character-memory address width.
REQ-002 Parameter LINE_W, default 6, line-index width.
REQ-003 Parameter LEN_W, default 6, line-length width.
REQ-004 Parameter CHAR_W, default 8, character width; each memory word is 2*CHAR_W (lhs high half, rhs low half).
REQ-005 Parameter NUM_LINES, default 2**LINE_W, number of valid descriptor entries.
REQ-006 clk  in  1  clock; all state changes on the rising edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 req_valid / req_ready  in / out  1 / 1  line-request handshake.
REQ-009 req_line  in  LINE_W  requested line index.
REQ-010 req_mode  in  2  00 lhs only, 01 rhs only, 10 interleaved lhs then rhs, 11 reserved.
REQ-011 desc_addr  out  LINE_W  descriptor-table address.
REQ-012 desc_data  in  LEN_W+ADDR_W  descriptor {len, start}; valid one cycle after desc_addr.
REQ-013 mem_addr / mem_rd  out  ADDR_W / 1  character-memory address and read strobe.
REQ-014 mem_dout  in  2*CHAR_W  memory data; valid one cycle after the mem_rd cycle.
REQ-015 out_valid / out_ready  out / in  1 / 1  character-stream handshake.
REQ-016 out_char  out  CHAR_W  character; out_last  out  1  marks the final beat of a line.
REQ-017 done  out  1  one-cycle pulse when a request completes; err  out  1  qualifies done.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 FSM states: IDLE, DLOOK, DLATCH, MREAD, EMIT, FIN.
REQ-020 IDLE: req_ready=1; on req_valid, latch req_line/req_mode and go to DLOOK.
REQ-021 Out-of-range request (req_line >= NUM_LINES or req_mode==11): accept, go to FIN with err=1, and emit no characters.
REQ-022 DLOOK: desc_addr = latched line; next state DLATCH.
REQ-023 DLATCH: capture start/len from desc_data; len==0 -> FIN with err=0; otherwise mem_addr=start, remaining=len, then MREAD.
REQ-024 MREAD: mem_rd=1 for exactly one cycle; next state EMIT, registering mem_dout.
REQ-025 EMIT: out_valid=1 and out_char stable until out_valid&&out_ready; out_char is not changed while out_valid=1 and out_ready=0.
REQ-026 Interleaved mode: each word yields two beats, lhs then rhs; other modes yield one beat per word.
REQ-027 After the last beat of a word: decrement remaining; if nonzero, set mem_addr=mem_addr+1 (mod 2**ADDR_W, wraps) and go to MREAD; else go to FIN.
REQ-028 out_last=1 only on the final beat of the final word.
REQ-029 FIN: done=1 for one cycle, then IDLE; err is low whenever done is low.
REQ-030 Latency: request accepted at cycle T gives the first out_valid at T+4.
REQ-031 Throughput: 2 cycles per word per beat-group plus stall cycles; mem_rd is never asserted while out_valid=1.
REQ-032 Requests are not accepted while busy=1; no abort path exists other than reset.

Reset
REQ-033 While rst_n=0: state IDLE, and req_ready, out_valid, out_last, done, err, mem_rd, busy = 0.
REQ-034 While rst_n=0: mem_addr, desc_addr, out_char = 0.
REQ-035 Reset mid-line discards the in-flight line with no done pulse; req_ready=1 on the first cycle after release.

Structure
REQ-036 Shared package line_stream_pkg holds the mode encodings, state enum and default parameter constants.
REQ-037 A single sub-module, line_desc_unpack, splits desc_data into start/len; everything else lives in line_streamer.

Verification
REQ-038 Line 0, descriptor {len=3,start=0}, mode 10, out_ready=1 -> six beats lhs0,rhs0,lhs1,rhs1,lhs2,rhs2; first beat at T+4; out_last on beat 6; done 1 cycle later with err=0.
REQ-039 Mode 00, len=2, out_ready low for 5 cycles on beat 1 -> out_char holds; no mem_rd during the stall; exactly 2 beats delivered.
REQ-040 Descriptor len=0 -> no out_valid; done=1 with err=0 at T+3.
REQ-041 req_line=NUM_LINES (NUM_LINES=40) or mode 11 -> no desc/mem access; done=1 with err=1.
REQ-042 start=255, len=2, ADDR_W=8 -> mem_addr sequence 255, 0.
REQ-043 rst_n low during the second beat -> all outputs zero; no done pulse; next request serviced normally.
